// File: rtl/scoreboard_display_ctrl.sv
// Chooses which 16-bit word the 4-digit scoreboard shows: score, a timed message, or a blinking alert.
// The priority is alert > message > score. All outputs are registered and change on the edge that samples the request.
module scoreboard_display_ctrl #(
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int BLINK_CYCLES = 12_500_000,
  parameter int CW           = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] score_digits,
  input  logic        msg_req,
  input  logic [15:0] msg_digits,
  input  logic        alert_req,
  input  logic [15:0] alert_digits,
  output logic        msg_ack,
  output logic [15:0] digits,
  output logic [1:0]  src,
  output logic        blank
);

  typedef enum logic [1:0] {
    S_SCORE = 2'd0,
    S_MSG   = 2'd1,
    S_ALERT = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] BLINK_TOP = CW'(BLINK_CYCLES - 1);

  state_t          state;
  logic [CW-1:0]   hold_cnt;
  logic [CW-1:0]   blink_cnt;
  logic [15:0]     msg_lat;

  // The encoding of the state matches the src code, so src is the state register.
  assign src = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_SCORE;
      digits    <= 16'h0000;
      blank     <= 1'b0;
      msg_ack   <= 1'b0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      msg_lat   <= 16'h0000;
    end else begin
      msg_ack <= 1'b0;
      case (state)
        S_SCORE, S_MSG: begin
          if (alert_req) begin
            state     <= S_ALERT;
            digits    <= alert_digits;
            blink_cnt <= '0;
            blank     <= 1'b0;
            hold_cnt  <= '0;
          end else if (msg_req) begin
            state    <= S_MSG;
            msg_lat  <= msg_digits;
            digits   <= msg_digits;
            hold_cnt <= HOLD_LD;
            msg_ack  <= 1'b1;
          end else if (state == S_MSG && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
            digits   <= msg_lat;
          end else begin
            state  <= S_SCORE;
            digits <= score_digits;
          end
        end
        S_ALERT: begin
          if (alert_req) begin
            digits <= alert_digits;
            if (blink_cnt == BLINK_TOP) begin
              blink_cnt <= '0;
              blank     <= ~blank;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end else begin
            state     <= S_SCORE;
            digits    <= score_digits;
            blank     <= 1'b0;
            blink_cnt <= '0;
          end
        end
        default: begin
          state  <= S_SCORE;
          digits <= score_digits;
          blank  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scoreboard_display_ctrl.sv
// Runs directed scenarios and then random traffic into scoreboard_display_ctrl.
// Every cycle is checked against a reference model that tracks the display mode.
module tb_scoreboard_display_ctrl;

  localparam int HOLD  = 4;
  localparam int BLINK = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] score_digits, msg_digits, alert_digits;
  logic        msg_req, alert_req;
  logic        msg_ack, blank;
  logic [15:0] digits;
  logic [1:0]  src;

  int n_chk  = 0;
  int n_fail = 0;

  // The reference model tracks the mode, the cycles left on the message, and the cycle index inside an alert.
  int          m_mode = 0;
  int          m_left = 0;
  int          m_acyc = 0;
  logic [15:0] m_msg  = 16'h0;
  logic [15:0] e_dig;
  logic        e_ack, e_blank;

  scoreboard_display_ctrl #(.HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK), .CW(26)) dut (
    .clk(clk), .rst(rst), .score_digits(score_digits), .msg_req(msg_req),
    .msg_digits(msg_digits), .alert_req(alert_req), .alert_digits(alert_digits),
    .msg_ack(msg_ack), .digits(digits), .src(src), .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    e_ack = 1'b0;
    if (rst) begin
      m_mode = 0; m_msg = 16'h0; m_left = 0; m_acyc = 0;
    end else if (m_mode == 2) begin
      if (alert_req) m_acyc++;
      else m_mode = 0;
    end else if (alert_req) begin
      m_mode = 2; m_acyc = 0;
    end else if (msg_req) begin
      m_mode = 1; m_msg = msg_digits; m_left = HOLD; e_ack = 1'b1;
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
    if (rst)              e_dig = 16'h0;
    else if (m_mode == 0) e_dig = score_digits;
    else if (m_mode == 1) e_dig = m_msg;
    else                  e_dig = alert_digits;
    e_blank = (m_mode == 2) ? (((m_acyc / BLINK) % 2) == 1) : 1'b0;
    #1;
    chk("digits",  digits,  e_dig);
    chk("src",     16'(src), 16'(m_mode));
    chk("blank",   16'(blank), 16'(e_blank));
    chk("msg_ack", 16'(msg_ack), 16'(e_ack));
  endtask

  initial begin
    bit pat [10] = '{0,0,0,1,1,1,0,0,0,1};
    int n;
    rst = 1'b1; msg_req = 1'b0; alert_req = 1'b0;
    score_digits = 16'h1A1B; msg_digits = 16'h0; alert_digits = 16'h0;
    tick(); tick();
    chk("rst_digits", digits, 16'h0000);
    rst = 1'b0;
    tick();
    chk("idle_digits", digits, 16'h1A1B);

    // The first message is interrupted after 2 display cycles by a second request, so it shows for 2 + 4 = 6 cycles in total.
    msg_req = 1'b1; msg_digits = 16'h5E11;
    tick();
    msg_req = 1'b0;
    chk("msg_first", digits, 16'h5E11);
    tick();
    msg_req = 1'b1; msg_digits = 16'h0002;
    tick();
    msg_req = 1'b0;
    chk("restart_ack", 16'(msg_ack), 16'd1);
    n = 3;
    for (int i = 0; i < 20 && src == 2'd1; i++) begin
      tick();
      if (src == 2'd1) n++;
    end
    chk("msg_total", 16'(n), 16'd6);

    // Message with no interruption: it shows for exactly HOLD cycles.
    msg_req = 1'b1; msg_digits = 16'h7777;
    tick();
    msg_req = 1'b0;
    n = 1;
    for (int i = 0; i < 20 && src == 2'd1; i++) begin
      tick();
      if (src == 2'd1) n++;
    end
    chk("msg_hold", 16'(n), 16'(HOLD));

    // An alert preempts the message, and a request made during the alert gets no ack.
    msg_req = 1'b1; msg_digits = 16'h3333;
    tick();
    msg_req = 1'b0;
    alert_req = 1'b1; alert_digits = 16'hDEAD;
    for (int i = 0; i < 10; i++) begin
      msg_req = (i == 5);
      msg_digits = 16'h4444;
      tick();
      chk("blink_pat", 16'(blank), 16'(pat[i]));
    end
    msg_req = 1'b0; alert_req = 1'b0;
    tick();
    chk("alert_exit", 16'(src), 16'd0);

    // Alert and message requested on the same cycle from SCORE: the alert wins.
    alert_req = 1'b1; msg_req = 1'b1; alert_digits = 16'hBEEF;
    tick();
    msg_req = 1'b0;
    chk("both_ack", 16'(msg_ack), 16'd0);
    tick(); tick(); tick();
    chk("pre_rst_blank", 16'(blank), 16'd1);
    rst = 1'b1; msg_req = 1'b1;
    tick();
    rst = 1'b0; msg_req = 1'b0; alert_req = 1'b0;
    tick();

    for (int i = 0; i < 3000; i++) begin
      score_digits = 16'($urandom); msg_digits = 16'($urandom); alert_digits = 16'($urandom);
      if ($urandom_range(11) == 0) alert_req = ~alert_req;
      msg_req = ($urandom_range(4) == 0);
      rst = ($urandom_range(99) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/scoreboard_display_ctrl.md
# scoreboard_display_ctrl

Arbitrates the 4-digit seven-segment scoreboard between three requesters: live score, timed messages and a high-priority alert. It presents one registered 16-bit `digits` word (four 4-bit codes, digit 3 in [15:12]) to `displayNumber`. It also produces a `blank` phase that the top level uses to gate `AN` for blinking. It sits between the game logic and `displayNumber`; `displayNumber` itself is unchanged.

## Interface
Parameters:
- HOLD_CYCLES, 50_000_000: number of cycles a message stays on screen (1 s at 50 MHz); legal range ≥ 1.
- BLINK_CYCLES, 12_500_000: cycles per blank/unblank half-period during an alert; legal range ≥ 1.
- CW, 26: width of the hold and blink counters; must hold HOLD_CYCLES-1 and BLINK_CYCLES-1.

Ports:
- clk  in  1  system clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- score_digits  in  16  live score codes; always valid.
- msg_req  in  1  one-cycle pulse requesting that a message be shown.
- msg_digits  in  16  message codes; sampled only in the cycle msg_req is accepted.
- alert_req  in  1  level; alert is shown while it is high.
- alert_digits  in  16  alert codes; live, not latched.
- msg_ack  out  1  one-cycle pulse: the message was accepted.
- digits  out  16  registered word to `displayNumber.digits`.
- src  out  2  registered source indicator: 0 = score, 1 = message, 2 = alert.
- blank  out  1  registered; when 1, the top level forces all `AN` high (display off).

## Operation
- Three states: SCORE, MSG, ALERT. Fixed priority: alert > message > score.
- **SCORE**
  - digits ← score_digits.
  - If alert_req = 1: go to ALERT.
  - Else if msg_req = 1: latch msg_digits, load hold counter with HOLD_CYCLES-1, pulse msg_ack, go to MSG.
- **MSG**
  - digits ← latched message.
  - If alert_req = 1: go to ALERT. The message is dropped; there is no resume.
  - Else if msg_req = 1: re-latch msg_digits, reload hold counter, pulse msg_ack, stay in MSG (restart).
  - Else if hold counter = 0: go to SCORE.
  - Else: decrement the hold counter.
- **ALERT**
  - digits ← alert_digits, updated every cycle.
  - msg_req is ignored: no latch, no ack. Requesters detect the missing ack and may retry.
  - When alert_req = 0: go to SCORE.
- **Blink** (active only in ALERT)
  - On entry to ALERT: blink counter = 0, blank = 0.
  - Each ALERT cycle the blink counter increments. When it reaches BLINK_CYCLES-1, it returns to 0 and blank toggles.
  - In SCORE and MSG, blank = 0 and the blink counter is held at 0.
- Counters never wrap below 0. The hold counter is only compared and decremented in MSG.
- Simultaneous alert_req and msg_req in SCORE or MSG: alert wins and msg_ack stays 0.
- The next state is decided from the inputs as sampled in the cycle of the decision.

## Timing
- All outputs are registered. Latency from input to output is 1 cycle: a request sampled at edge k is visible on digits/src from edge k.
- msg_ack is high for exactly the one cycle after the accepting edge. It is never high in two consecutive cycles unless msg_req is pulsed on consecutive cycles.
- Message display duration is exactly HOLD_CYCLES cycles with src = 1, then src = 0 on the following cycle, provided there is no interruption.
- Alert: src = 2 starts the cycle after alert_req is first sampled high. src = 0 starts the cycle after alert_req is sampled low.
- In ALERT, blank first goes to 1 after BLINK_CYCLES cycles in ALERT.
- **Reset** (rst sampled high at an edge), including mid-message or mid-alert:
  - State → SCORE, digits = 16'h0000, src = 0, blank = 0, msg_ack = 0.
  - Both counters and the latched message are cleared.
  - Requests present during reset are ignored.
  - The first non-reset cycle behaves as SCORE.

## Test plan
Bench parameters: HOLD_CYCLES = 4, BLINK_CYCLES = 3.
- **Reset, then idle.** Drive score_digits = 16'h1A1B. Expected: digits = 16'h0000 during reset; 16'h1A1B, src = 0, blank = 0 one cycle after release.
- **Message display.** Pulse msg_req with msg_digits = 16'h5E11. Expected: msg_ack high for 1 cycle; digits = 16'h5E11 with src = 1 for exactly 4 cycles; then back to score.
- **Message restart.** Pulse msg_req again (16'h0002) in the 3rd message cycle. Expected: second msg_ack; digits = 16'h0002 for 4 further cycles, for 6 message cycles total.
- **Alert preempts message.** Raise alert_req with alert_digits = 16'hDEAD during a message, holding it 10 cycles. Expected: src = 2 next cycle; blank pattern 0,0,0,1,1,1,0,0,0,1; message not resumed; src = 0 after alert_req drops.
- **Request during alert.** Pulse msg_req while alert_req = 1. Expected: msg_ack stays 0 and the displayed word stays the alert. Also pulse msg_req together with alert_req in SCORE. Expected: ALERT entered, no ack.
- **Reset mid-alert.** Assert rst while in ALERT with blank = 1. Expected: next cycle digits = 0, src = 0, blank = 0, msg_ack = 0.
